// File: rtl/tmr_scrub_pkg.sv
// Shared types and constants for the triple-redundant scrubbed memory.
package tmr_scrub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RD,
    WB
  } scrub_state_e;

  localparam logic [1:0] COPY0     = 2'd0;
  localparam logic [1:0] COPY1     = 2'd1;
  localparam logic [1:0] COPY2     = 2'd2;
  localparam logic [1:0] COPY_NONE = 2'd3;

endpackage

// File: rtl/tmr_voter.sv
// Bitwise 2-of-3 majority voter; also reports how far each replica
// deviates from the voted word.
module tmr_voter #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]        in0,
  input  logic [DATA_W-1:0]        in1,
  input  logic [DATA_W-1:0]        in2,
  output logic [DATA_W-1:0]        voted,
  output logic [2:0][DATA_W-1:0]   mask
);

  always_comb begin
    voted   = (in0 & in1) | (in1 & in2) | (in0 & in2);
    mask[0] = in0 ^ voted;
    mask[1] = in1 ^ voted;
    mask[2] = in2 ^ voted;
  end

endmodule

// File: rtl/tmr_scrub_mem.sv
// Triple-replica memory with a voted user port and a background scrubber
// that writes the voted word back whenever a replica disagrees.
module tmr_scrub_mem
  import tmr_scrub_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int SCRUB_GAP = 4,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              scrub_en,
  input  logic              inj_en,
  input  logic [1:0]        inj_copy,
  input  logic [ADDR_W-1:0] inj_addr,
  input  logic [DATA_W-1:0] inj_mask,
  output logic              corr_pulse,
  output logic              multi_err,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] scrub_addr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int GAP_W = (SCRUB_GAP < 2) ? 1 : $clog2(SCRUB_GAP);

  logic [DATA_W-1:0] mem_q [3][DEPTH];
  logic [DATA_W-1:0] mem_d [3][DEPTH];

  scrub_state_e            state_q, state_d;
  logic [ADDR_W-1:0]       scrub_addr_q, scrub_addr_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    stale_q, stale_d;
  logic [DATA_W-1:0]       sc_voted_q, sc_voted_d;
  logic [2:0][DATA_W-1:0]  sc_mask_q, sc_mask_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;
  logic                    corr_q, corr_d;
  logic                    multi_q, multi_d;
  logic [CNT_W-1:0]        err_q, err_d;

  logic [DATA_W-1:0]       rd_voted;
  logic [2:0][DATA_W-1:0]  unused_rd_mask;
  logic [DATA_W-1:0]       sc_voted;
  logic [2:0][DATA_W-1:0]  sc_mask;
  logic                    busy;
  logic                    wb_write;
  logic [2:0]              bad;

  tmr_voter #(.DATA_W(DATA_W)) u_rd_voter (
    .in0   (mem_q[0][addr]),
    .in1   (mem_q[1][addr]),
    .in2   (mem_q[2][addr]),
    .voted (rd_voted),
    .mask  (unused_rd_mask)
  );

  tmr_voter #(.DATA_W(DATA_W)) u_sc_voter (
    .in0   (mem_q[0][scrub_addr_q]),
    .in1   (mem_q[1][scrub_addr_q]),
    .in2   (mem_q[2][scrub_addr_q]),
    .voted (sc_voted),
    .mask  (sc_mask)
  );

  always_comb begin
    mem_d        = mem_q;
    state_d      = state_q;
    scrub_addr_d = scrub_addr_q;
    gap_d        = gap_q;
    stale_d      = stale_q;
    sc_voted_d   = sc_voted_q;
    sc_mask_d    = sc_mask_q;
    err_d        = err_q;
    corr_d       = 1'b0;
    multi_d      = 1'b0;
    wb_write     = 1'b0;
    busy         = we | re;
    rvalid_d     = re;
    rdata_d      = re ? rd_voted : rdata_q;
    bad          = {|sc_mask_q[2], |sc_mask_q[1], |sc_mask_q[0]};

    case (state_q)
      IDLE: begin
        if (scrub_en) begin
          state_d = (SCRUB_GAP == 0) ? RD : WAIT;
          gap_d   = '0;
        end
      end
      WAIT: begin
        if (!scrub_en) begin
          state_d = IDLE;
        end else if (gap_q == GAP_W'(SCRUB_GAP - 1)) begin
          state_d = RD;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      RD: begin
        if (!busy) begin
          sc_voted_d = sc_voted;
          sc_mask_d  = sc_mask;
          stale_d    = 1'b0;
          state_d    = WB;
        end
      end
      WB: begin
        // A user write landing on the latched word makes the snapshot stale.
        if (busy) begin
          if (we && addr == scrub_addr_q) stale_d = 1'b1;
        end else begin
          if (!stale_q && |bad) begin
            wb_write = 1'b1;
            corr_d   = 1'b1;
            multi_d  = (bad[0] & bad[1]) | (bad[1] & bad[2]) | (bad[0] & bad[2]);
            if (err_q != {CNT_W{1'b1}}) err_d = err_q + 1'b1;
          end
          scrub_addr_d = scrub_addr_q + 1'b1;
          gap_d        = '0;
          state_d      = !scrub_en ? IDLE : ((SCRUB_GAP == 0) ? RD : WAIT);
        end
      end
      default: state_d = IDLE;
    endcase

    if (wb_write) begin
      for (int k = 0; k < 3; k++) mem_d[k][scrub_addr_q] = sc_voted_q;
    end
    if (we) begin
      for (int k = 0; k < 3; k++) mem_d[k][addr] = wdata;
    end
    // Injection lands on top of any writeback, but a user write to the same word wins.
    if (inj_en && inj_copy != COPY_NONE && !(we && addr == inj_addr)) begin
      mem_d[inj_copy][inj_addr] = mem_d[inj_copy][inj_addr] ^ inj_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        for (int a = 0; a < DEPTH; a++) mem_q[k][a] <= '0;
      end
      state_q      <= IDLE;
      scrub_addr_q <= '0;
      gap_q        <= '0;
      stale_q      <= 1'b0;
      sc_voted_q   <= '0;
      sc_mask_q    <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      corr_q       <= 1'b0;
      multi_q      <= 1'b0;
      err_q        <= '0;
    end else begin
      mem_q        <= mem_d;
      state_q      <= state_d;
      scrub_addr_q <= scrub_addr_d;
      gap_q        <= gap_d;
      stale_q      <= stale_d;
      sc_voted_q   <= sc_voted_d;
      sc_mask_q    <= sc_mask_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      corr_q       <= corr_d;
      multi_q      <= multi_d;
      err_q        <= err_d;
    end
  end

  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign corr_pulse = corr_q;
  assign multi_err  = multi_q;
  assign err_count  = err_q;
  assign scrub_addr = scrub_addr_q;

endmodule

// File: tb/tb_tmr_scrub_mem.sv
// Directed bench for tmr_scrub_mem: reads go through a scoreboard queue,
// scrubber corrections are tallied by the same monitor process.
module tb_tmr_scrub_mem;
  import tmr_scrub_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              we = 1'b0;
  logic              re = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              scrub_en = 1'b0;
  logic              inj_en = 1'b0;
  logic [1:0]        inj_copy = 2'd0;
  logic [ADDR_W-1:0] inj_addr = '0;
  logic [DATA_W-1:0] inj_mask = '0;
  logic              corr_pulse;
  logic              multi_err;
  logic [CNT_W-1:0]  err_count;
  logic [ADDR_W-1:0] scrub_addr;

  int checks = 0;
  int failures = 0;
  int corr_seen = 0;
  int multi_seen = 0;
  logic [ADDR_W-1:0] last_corr_addr = '0;
  logic [DATA_W-1:0] expq[$];
  logic [DATA_W-1:0] exp_mem [DEPTH];

  tmr_scrub_mem #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SCRUB_GAP(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .scrub_en(scrub_en), .inj_en(inj_en),
    .inj_copy(inj_copy), .inj_addr(inj_addr), .inj_mask(inj_mask),
    .corr_pulse(corr_pulse), .multi_err(multi_err), .err_count(err_count),
    .scrub_addr(scrub_addr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // One user-port cycle; the expected read word is queued before the write updates the model.
  task automatic applyStimulus(input logic w, input logic r, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d);
    we = w; re = r; addr = a; wdata = d;
    if (r) expq.push_back(exp_mem[a]);
    if (w) exp_mem[a] = d;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic injectFault(input logic [1:0] c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] m);
    inj_en = 1'b1; inj_copy = c; inj_addr = a; inj_mask = m;
    @(negedge clk);
    inj_en = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic waitCorr(input int target, input int budget);
    int n = 0;
    while (corr_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("corr_wait", 32'(corr_seen >= target), 32'd1);
  endtask

  task automatic waitState(input scrub_state_e s, input int budget);
    int n = 0;
    while (dut.state_q != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("state_wait", 32'(dut.state_q == s), 32'd1);
  endtask

  task automatic checkWord(input string name, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    int bad = 0;
    for (int k = 0; k < 3; k++) if (dut.mem_q[k][a] !== v) bad++;
    checkOutput(name, 32'(bad), 32'd0);
  endtask

  // Scoreboard monitor: pops one expected word per rvalid and tallies scrub corrections.
  always @(posedge clk) begin
    #1;
    if (rvalid) begin
      if (expq.size() == 0) checkOutput("rd_unexpected", 32'd1, 32'd0);
      else checkOutput("rdata", 32'(rdata), 32'(expq.pop_front()));
    end
    if (corr_pulse) begin
      corr_seen++;
      if (multi_err) multi_seen++;
      last_corr_addr = scrub_addr - 4'd1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cb;
    int mb;
    logic [ADDR_W-1:0] rd_addrs [4];
    rd_addrs = '{4'd3, 4'd5, 4'd6, 4'd4};
    for (int a = 0; a < DEPTH; a++) exp_mem[a] = '0;

    // Test 1: reset values, write/read, write+read same cycle, injection vs write
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_rvalid", 32'(rvalid), 0);
    checkOutput("rst_err", 32'(err_count), 0);
    checkOutput("rst_scrub_addr", 32'(scrub_addr), 0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(1);
    applyStimulus(1, 0, 3, 8'h5A);
    applyStimulus(0, 1, 3, 0);
    waitCycles(2);
    checkOutput("t1_err", 32'(err_count), 0);
    applyStimulus(1, 1, 3, 8'h77);
    applyStimulus(0, 1, 3, 0);
    inj_en = 1'b1; inj_copy = COPY0; inj_addr = 4; inj_mask = 8'hFF;
    applyStimulus(1, 0, 4, 8'h12);
    inj_en = 1'b0;
    checkWord("t1_inj_dropped", 4, 8'h12);
    waitCycles(3);
    checkOutput("t1_rdata_hold", 32'(rdata), 32'h77);
    checkOutput("t1_rvalid_low", 32'(rvalid), 0);

    // Test 2: single-copy fault corrected exactly once over two passes
    injectFault(COPY1, 3, 8'h0F);
    checkOutput("t2_injected", 32'(dut.mem_q[1][3]), 32'h78);
    applyStimulus(0, 1, 3, 0);
    scrub_en = 1'b1;
    waitCycles(200);
    scrub_en = 1'b0;
    checkOutput("t2_corr_count", 32'(corr_seen), 1);
    checkOutput("t2_multi_count", 32'(multi_seen), 0);
    checkOutput("t2_corr_addr", 32'(last_corr_addr), 3);
    checkOutput("t2_err", 32'(err_count), 1);
    checkWord("t2_repaired", 3, 8'h77);
    waitCycles(10);

    // Test 3: two copies faulty in different bits -> multi_err
    injectFault(COPY0, 5, 8'h01);
    injectFault(COPY2, 5, 8'h80);
    applyStimulus(0, 1, 5, 0);
    cb = corr_seen; mb = multi_seen;
    scrub_en = 1'b1;
    waitCorr(cb + 1, 200);
    scrub_en = 1'b0;
    checkOutput("t3_corr_addr", 32'(last_corr_addr), 5);
    checkOutput("t3_multi", 32'(multi_seen), 32'(mb + 1));
    checkOutput("t3_err", 32'(err_count), 2);
    waitCycles(5);
    checkWord("t3_repaired", 5, 8'h00);

    // Test 4: continuous reads starve the scrubber, then it resumes in place
    checkOutput("t4_addr_start", 32'(scrub_addr), 6);
    cb = corr_seen;
    scrub_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 20) begin
        inj_en = 1'b1; inj_copy = COPY0; inj_addr = 7; inj_mask = 8'h11;
      end
      applyStimulus(0, 1, rd_addrs[i % 4], 0);
      inj_en = 1'b0;
    end
    checkOutput("t4_addr_frozen", 32'(scrub_addr), 6);
    checkOutput("t4_no_corr", 32'(corr_seen), 32'(cb));

    // Test 5: user write to the word held in WB makes the scrub result stale
    waitState(WB, 20);
    checkOutput("t5_resumed_addr", 32'(scrub_addr), 6);
    waitCycles(1);
    waitState(WB, 20);
    checkOutput("t5_wb_addr", 32'(scrub_addr), 7);
    applyStimulus(1, 0, 7, 8'h33);
    waitCycles(3);
    checkOutput("t5_no_corr", 32'(corr_seen), 32'(cb));
    checkOutput("t5_err", 32'(err_count), 2);
    checkOutput("t5_addr_next", 32'(scrub_addr), 8);
    scrub_en = 1'b0;
    waitCycles(8);
    applyStimulus(0, 1, 7, 0);
    checkWord("t5_copies", 7, 8'h33);

    // Test 6: saturation of the 2-bit counter, then reset during writeback
    injectFault(COPY0, 9, 8'h01);
    injectFault(COPY1, 10, 8'h02);
    injectFault(COPY2, 11, 8'h04);
    injectFault(COPY0, 12, 8'h08);
    cb = corr_seen; mb = multi_seen;
    scrub_en = 1'b1;
    waitCorr(cb + 1, 100);
    checkOutput("t6_err_first", 32'(err_count), 3);
    waitCorr(cb + 4, 100);
    checkOutput("t6_err_sat", 32'(err_count), 3);
    checkOutput("t6_multi", 32'(multi_seen), 32'(mb));
    injectFault(COPY1, 14, 8'h40);
    waitState(WB, 40);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_rdata", 32'(rdata), 0);
    checkOutput("t6_rst_rvalid", 32'(rvalid), 0);
    checkOutput("t6_rst_corr", 32'(corr_pulse), 0);
    checkOutput("t6_rst_multi", 32'(multi_err), 0);
    checkOutput("t6_rst_err", 32'(err_count), 0);
    checkOutput("t6_rst_addr", 32'(scrub_addr), 0);
    checkOutput("t6_rst_state", 32'(dut.state_q == IDLE), 1);
    begin
      int nz = 0;
      for (int k = 0; k < 3; k++)
        for (int a = 0; a < DEPTH; a++) if (dut.mem_q[k][a] !== '0) nz++;
      checkOutput("t6_rst_mem", 32'(nz), 0);
    end
    @(negedge clk);
    scrub_en = 1'b0;
    cb = corr_seen;
    waitCycles(2);
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) exp_mem[a] = '0;
    waitCycles(1);
    applyStimulus(0, 1, 3, 0);
    applyStimulus(0, 1, 7, 0);
    waitCycles(3);
    checkOutput("t6_post_err", 32'(err_count), 0);
    checkOutput("t6_post_corr", 32'(corr_seen), 32'(cb));
    checkOutput("sb_empty", 32'(expq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmr_scrub_mem.md
Name: tmr_scrub_mem

Overview:
Parametrised successor to the TMR memory. Holds three replica arrays, serves a single user read/write port with majority-voted read data, and runs a background scrubber. The scrubber walks all addresses, votes the three copies and writes corrected data back to all of them. It reports the corrections it makes and keeps a saturating error count. Sits beside tmr_counter under the top level; a fault-injection port is exposed for verification.

Parameters:
ADDR_W, 4, address width; DEPTH = 2**ADDR_W
DATA_W, 8, word width
SCRUB_GAP, 4, idle cycles between scrubbed words (0 allowed)
CNT_W, 8, width of err_count

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
we  in  1  user write strobe
re  in  1  user read strobe
addr  in  ADDR_W  user address
wdata  in  DATA_W  user write data
rdata  out  DATA_W  voted read data
rvalid  out  1  rdata valid pulse
scrub_en  in  1  enable background scrubbing
inj_en  in  1  fault-injection strobe
inj_copy  in  2  target replica 0..2 (3 = ignored)
inj_addr  in  ADDR_W  injection address
inj_mask  in  DATA_W  bits XOR-flipped in the target copy
corr_pulse  out  1  scrubber corrected a word
multi_err  out  1  corrected word had faults in two or more copies
err_count  out  CNT_W  saturating count of corrected words
scrub_addr  out  ADDR_W  next/current scrub address

Behaviour:
- Reset is asynchronous, active-low:
  - all three arrays cleared to 0;
  - rdata=0, rvalid=0, corr_pulse=0, multi_err=0, err_count=0, scrub_addr=0;
  - FSM goes to IDLE.
- User write: on we, wdata is written to all three copies at the clock edge.
- User read: re in cycle t gives rvalid=1 and rdata=vote(copies[addr]) in cycle t+1.
  - rdata holds its value when rvalid=0.
  - A user read never corrects the arrays and never counts.
- we and re in the same cycle: the write is performed; the read returns the pre-write voted word.
- Vote is bitwise majority. Copy k's mismatch mask = copy_k XOR voted.
- Injection: XORs inj_mask into copy inj_copy at inj_addr.
  - Dropped if a user write hits inj_addr in the same cycle (the user write wins).
  - Otherwise applied regardless of scrubber state.
- The port is busy in any cycle with we or re. The scrubber uses the arrays only when the port is not busy.
- Scrub FSM states:
  - IDLE: leave to WAIT when scrub_en=1. If SCRUB_GAP=0, go directly to RD.
  - WAIT: gap counter counts SCRUB_GAP cycles, then goes to RD.
  - RD: if the port is not busy, latch the voted word and the three mismatch masks for scrub_addr, clear stale, go to WB. Otherwise stay in RD.
  - WB: a user write to scrub_addr in this state sets stale. When the port is not busy:
    - if stale: no write and no count;
    - else if any mask is non-zero: write the voted word to all copies, corr_pulse=1 for one cycle, err_count+1 (saturating at 2**CNT_W-1), multi_err=1 for the same cycle if two or more masks are non-zero.
    - Then scrub_addr increments, wrapping DEPTH-1 to 0. Go to WAIT, or to IDLE if scrub_en=0.
- scrub_en deasserting mid-word: the current word completes, then the FSM goes to IDLE. scrub_addr is retained.
- Reset mid-scrub aborts immediately; no partial writeback.

Decomposition:
- Package tmr_scrub_pkg holds:
  - the scrub FSM state enum (IDLE, WAIT, RD, WB);
  - replica index constants COPY0..COPY2 and COPY_NONE=3.
- One sub-module, tmr_voter, parametrised by DATA_W.
  - Combinational: takes three words, outputs the voted word and three mismatch masks.
  - Instantiated twice: once for the user read path, once for the scrub path.

Test Plan:
1. Reset; write 0x5A to addr 3; re addr 3 -> next cycle rvalid=1, rdata=0x5A; err_count=0.
2. Inject copy1 addr3 mask 0x0F; read addr3 -> rdata=0x5A. Set scrub_en (GAP=4) -> corr_pulse once when scrub_addr=3, multi_err=0, err_count=1. Second full pass -> no further pulses.
3. addr5 holds 0x00; inject copy0 mask 0x01 and copy2 mask 0x80 -> read returns 0x00. The scrub reaches addr5 -> corr_pulse=1, multi_err=1, err_count increments; all copies back to 0x00.
4. Hold re=1 continuously while scrub_en=1 -> scrub_addr frozen, no corr_pulse, rdata always correct. Release -> scrubbing resumes from the same address.
5. Inject a fault at addr 7; user writes 0x33 to addr 7 while the FSM is in WB for addr 7 -> no corr_pulse, err_count unchanged; read addr7 -> 0x33 with all copies equal.
6. CNT_W=2: create 4 correctable words and scrub them -> err_count saturates at 3. Assert rst_n=0 during WB -> all outputs 0, FSM in IDLE, arrays cleared.
